mcycle_unit: RTL



---
 rtl/mcycle_pkg.sv | 27 ++
 rtl/mcycle_abs_neg.sv | 19 +
 rtl/mcycle_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mcycle_pkg.sv
// mcycle_pkg
// Shared definitions for the multi-cycle multiply/divide unit:
//   - operation encodings carried on MCycleOp
//   - controller state encoding
//   - iteration counter width helper
package mcycle_pkg;

    typedef enum logic [1:0] {
        MCYCLE_SMUL = 2'b00,
        MCYCLE_UMUL = 2'b01,
        MCYCLE_SDIV = 2'b10,
        MCYCLE_UDIV = 2'b11
    } mcycle_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PREP    = 2'b01,
        ST_COMPUTE = 2'b10,
        ST_FIX     = 2'b11
    } mcycle_state_e;

    // Width of the COMPUTE iteration counter: clog2(width+1).
    function automatic int mcycle_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mcycle_abs_neg.sv
// mcycle_abs_neg
// Conditional two's-complement: result = negate ? -value : value.
// Used both to take magnitudes of signed operands and to restore the
// sign of products, quotients and remainders.
// Ports:
//   value   in  DATA_W  operand
//   negate  in  1       1 = output the two's complement of value
//   result  out DATA_W  conditionally negated value
module mcycle_abs_neg #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] value,
    input  logic              negate,
    output logic [DATA_W-1:0] result
);

    assign result = negate ? ((~value) + DATA_W'(1)) : value;

endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit
// Multi-cycle WIDTH x WIDTH multiply (2*WIDTH-bit product) and WIDTH / WIDTH
// divide (quotient, remainder), signed or unsigned. Sequence per operation:
// IDLE -> PREP (magnitudes, result signs) -> COMPUTE (one bit per cycle)
// -> FIX (sign restore, result register) -> IDLE with a one-cycle Done.
// Ports:
//   CLK        in   clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   Start      in   request, sampled only in IDLE
//   MCycleOp   in   2  00 smul, 01 umul, 10 sdiv, 11 udiv
//   Operand1   in   WIDTH multiplicand / dividend
//   Operand2   in   WIDTH multiplier / divisor
//   Result1    out  WIDTH product low half / quotient
//   Result2    out  WIDTH product high half / remainder
//   Busy       out  operation in progress (WIDTH+2 cycles)
//   Done       out  one-cycle pulse when results become valid
//   DivByZero  out  divide had a zero divisor; cleared at next accepted Start
// Build option:
//   MCYCLE_EARLY_TERM_EN  multiply leaves COMPUTE once the remaining
//                         multiplier bits are all zero (divide unchanged).
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CNT_W = mcycle_cnt_w(WIDTH);
    localparam int AW    = 2 * WIDTH;

    mcycle_state_e    state_q, state_d;
    mcycle_op_e       op_q, op_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    // Mul: running product. Div: {remainder, dividend/quotient shift register}.
    logic [AW-1:0]    acc_q, acc_d;
    // Mul: left-shifting multiplicand. Div: divisor magnitude in the low bits.
    logic [AW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic [WIDTH-1:0] res2_q, res2_d;
    logic             done_q, done_d;
    logic             dbz_flag_q, dbz_flag_d;

    logic             is_div, is_signed;
    logic             sign1, sign2;
    logic [WIDTH:0]   abs1_in, abs2_in, mag1, mag2;
    logic [AW-1:0]    fix_in, fix_out;
    logic [WIDTH-1:0] rem_out;
    logic [WIDTH:0]   rem_sh, trial;
    logic             last_iter;

    assign is_div    = (op_q == MCYCLE_SDIV) || (op_q == MCYCLE_UDIV);
    assign is_signed = (op_q == MCYCLE_SMUL) || (op_q == MCYCLE_SDIV);
    assign sign1     = is_signed & op1_q[WIDTH-1];
    assign sign2     = is_signed & op2_q[WIDTH-1];

    // Magnitudes are WIDTH+1 bits wide so that -2^(WIDTH-1) becomes an
    // exact +2^(WIDTH-1); unsigned operands are simply zero-extended.
    assign abs1_in = {sign1, op1_q};
    assign abs2_in = {sign2, op2_q};

    mcycle_abs_neg #(.DATA_W(WIDTH + 1)) u_abs1 (
        .value (abs1_in),
        .negate(sign1),
        .result(mag1)
    );

    mcycle_abs_neg #(.DATA_W(WIDTH + 1)) u_abs2 (
        .value (abs2_in),
        .negate(sign2),
        .result(mag2)
    );

    // One 2*WIDTH negator serves both the full product and the quotient
    // (the quotient is zero-extended; only its low half is kept).
    assign fix_in = is_div ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;

    mcycle_abs_neg #(.DATA_W(AW)) u_neg_res (
        .value (fix_in),
        .negate(neg_res_q),
        .result(fix_out)
    );

    mcycle_abs_neg #(.DATA_W(WIDTH)) u_neg_rem (
        .value (acc_q[AW-1:WIDTH]),
        .negate(neg_rem_q),
        .result(rem_out)
    );

    // Restoring-divide trial subtraction. The partial remainder stays below
    // the divisor, so bit WIDTH of the difference is a reliable borrow.
    assign rem_sh = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};

`ifdef MCYCLE_EARLY_TERM_EN
    assign last_iter = (cnt_q == '0) || (!is_div && (mplier_q[WIDTH-1:1] == '0));
`else
    assign last_iter = (cnt_q == '0);
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_d      = dbz_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        res1_d     = res1_q;
        res2_d     = res2_q;
        done_d     = 1'b0;
        dbz_flag_d = dbz_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    op_d       = mcycle_op_e'(MCycleOp);
                    op1_d      = Operand1;
                    op2_d      = Operand2;
                    dbz_flag_d = 1'b0;
                    state_d    = ST_PREP;
                end
            end

            ST_PREP: begin
                neg_res_d = sign1 ^ sign2;
                neg_rem_d = sign1;
                cnt_d     = CNT_W'(WIDTH - 1);
                if (is_div) begin
                    acc_d    = {{WIDTH{1'b0}}, mag1[WIDTH-1:0]};
                    mcand_d  = {{(WIDTH-1){1'b0}}, mag2};
                    mplier_d = '0;
                    dbz_d    = (op2_q == '0);
                end else begin
                    acc_d    = '0;
                    mcand_d  = {{(WIDTH-1){1'b0}}, mag1};
                    mplier_d = mag2[WIDTH-1:0];
                    dbz_d    = 1'b0;
                end
                state_d = ST_COMPUTE;
            end

            ST_COMPUTE: begin
                if (is_div) begin
                    if (!trial[WIDTH]) begin
                        acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (last_iter) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                if (is_div) begin
                    if (dbz_q) begin
                        // Zero divisor: all-ones quotient, dividend passed through untouched.
                        res1_d = '1;
                        res2_d = op1_q;
                    end else begin
                        res1_d = fix_out[WIDTH-1:0];
                        res2_d = rem_out;
                    end
                end else begin
                    res1_d = fix_out[WIDTH-1:0];
                    res2_d = fix_out[AW-1:WIDTH];
                end
                done_d     = 1'b1;
                dbz_flag_d = is_div & dbz_q;
                state_d    = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            op_q       <= MCYCLE_SMUL;
            op1_q      <= '0;
            op2_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            res1_q     <= '0;
            res2_q     <= '0;
            done_q     <= 1'b0;
            dbz_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_q      <= dbz_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            res1_q     <= res1_d;
            res2_q     <= res2_d;
            done_q     <= done_d;
            dbz_flag_q <= dbz_flag_d;
        end
    end

    assign Result1   = res1_q;
    assign Result2   = res2_q;
    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_flag_q;

endmodule
